mem_access_unit: RTL and testbench

- MEM-stage data-memory access controller for the RV32IMF pipeline.
- Consumes MEM_FWD_SEL to choose store data:
  - either the MEM-stage register value,
  - or the load result currently in WB (load-then-store hazard).
- Aligns byte/half/word stores, runs a request/ack handshake with data memory, and stalls the pipeline while an access is outstanding.
- Returns sign/zero-extended load data, registered for the MEM/WB stage.

---
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller.
// Picks store data from the MEM-stage register or the WB load result
// (load-then-store forwarding), aligns byte/half/word stores onto the
// 32-bit bus, runs a REQ/ACK handshake with data memory while stalling
// the pipeline, and returns a registered, extended load result.
//
// Ports:
//   CLK, RESET            clock (rising edge), async active-low reset
//   MEM_READ, MEM_WRITE   access request (write wins if both set)
//   FUNCT3                000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALU_RESULT            byte address
//   MEM_REG_DATA          store data from the MEM-stage register
//   WB_FWD_DATA           load result currently in WB
//   MEM_FWD_SEL           1 selects WB_FWD_DATA as store data
//   DMEM_REQ/WE/ADDR/WDATA/BE  registered memory request, held until ack
//   DMEM_RDATA, DMEM_ACK  read data and one-cycle completion pulse
//   BUSY                  pipeline stall request
//   LOAD_DATA, LOAD_VALID extended load result and one-cycle valid pulse
//   MISALIGNED            combinational misalignment flag (IDLE only)
//   BUS_ERROR             one-cycle pulse when the ack wait times out
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MEM_READ,
  input  logic                  MEM_WRITE,
  input  logic [2:0]            FUNCT3,
  input  logic [ADDR_WIDTH-1:0] ALU_RESULT,
  input  logic [31:0]           MEM_REG_DATA,
  input  logic [31:0]           WB_FWD_DATA,
  input  logic                  MEM_FWD_SEL,
  output logic                  DMEM_REQ,
  output logic                  DMEM_WE,
  output logic [ADDR_WIDTH-1:0] DMEM_ADDR,
  output logic [31:0]           DMEM_WDATA,
  output logic [3:0]            DMEM_BE,
  input  logic [31:0]           DMEM_RDATA,
  input  logic                  DMEM_ACK,
  output logic                  BUSY,
  output logic [31:0]           LOAD_DATA,
  output logic                  LOAD_VALID,
  output logic                  MISALIGNED,
  output logic                  BUS_ERROR
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic [1:0]              off_q, off_d;
  logic [2:0]              f3_q, f3_d;
  logic [31:0]             ld_q, ld_d;
  logic                    ld_valid_q, ld_valid_d;
  logic                    berr_q, berr_d;

  logic                    access;
  logic                    mis;
  logic [31:0]             store_src;
  logic [3:0]              be_new;
  logic [31:0]             wdata_new;
  logic [31:0]             shifted;
  logic [31:0]             ld_ext;
  logic [7:0]              cnt_inc;

  // Request decode: size from FUNCT3[1:0], lane placement from addr[1:0].
  always_comb begin
    access    = MEM_READ | MEM_WRITE;
    store_src = MEM_FWD_SEL ? WB_FWD_DATA : MEM_REG_DATA;
    case (FUNCT3[1:0])
      2'b01:   mis = ALU_RESULT[0];
      2'b10:   mis = |ALU_RESULT[1:0];
      default: mis = 1'b0;
    endcase
    case (FUNCT3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << ALU_RESULT[1:0];
        wdata_new = {4{store_src[7:0]}};
      end
      2'b01: begin
        be_new    = ALU_RESULT[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{store_src[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = store_src;
      end
    endcase
  end

  // Load extraction from the captured offset and access type.
  always_comb begin
    shifted = DMEM_RDATA >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {24'b0, shifted[7:0]};
      3'b101:  ld_ext = {16'b0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    off_d      = off_q;
    f3_d       = f3_q;
    ld_d       = ld_q;
    ld_valid_d = 1'b0;
    berr_d     = 1'b0;
    cnt_inc    = cnt_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        if (access && !mis) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = MEM_WRITE;
          addr_d  = {ALU_RESULT[ADDR_WIDTH-1:2], 2'b00};
          be_d    = be_new;
          wdata_d = MEM_WRITE ? wdata_new : '0;
          off_d   = ALU_RESULT[1:0];
          f3_d    = FUNCT3;
        end
      end
      S_WAIT: begin
        // Ack takes priority over a timeout reached in the same cycle.
        if (DMEM_ACK) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            ld_d       = ld_ext;
            ld_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == MaxWait) begin
            state_d = S_DONE;
            req_d   = 1'b0;
            berr_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      ld_q       <= '0;
      ld_valid_q <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      ld_q       <= ld_d;
      ld_valid_q <= ld_valid_d;
      berr_q     <= berr_d;
    end
  end

  assign DMEM_REQ   = req_q;
  assign DMEM_WE    = we_q;
  assign DMEM_ADDR  = addr_q;
  assign DMEM_WDATA = wdata_q;
  assign DMEM_BE    = be_q;
  assign LOAD_DATA  = ld_q;
  assign LOAD_VALID = ld_valid_q;
  assign BUS_ERROR  = berr_q;
  assign MISALIGNED = (state_q == S_IDLE) && access && mis;
  assign BUSY       = ((state_q == S_IDLE) && access && !mis) || (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed accesses, a transaction-level
// expectation model checked every cycle, and literal spot checks.
module tb_mem_access_unit;

  localparam int unsigned MAX_WAIT = 15;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_READ, MEM_WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ALU_RESULT, MEM_REG_DATA, WB_FWD_DATA;
  logic        MEM_FWD_SEL;
  logic        DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_ACK;
  logic        BUSY;
  logic [31:0] LOAD_DATA;
  logic        LOAD_VALID, MISALIGNED, BUS_ERROR;

  mem_access_unit #(.ADDR_WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .FUNCT3(FUNCT3), .ALU_RESULT(ALU_RESULT), .MEM_REG_DATA(MEM_REG_DATA),
    .WB_FWD_DATA(WB_FWD_DATA), .MEM_FWD_SEL(MEM_FWD_SEL),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_RDATA(DMEM_RDATA),
    .DMEM_ACK(DMEM_ACK), .BUSY(BUSY), .LOAD_DATA(LOAD_DATA),
    .LOAD_VALID(LOAD_VALID), .MISALIGNED(MISALIGNED), .BUS_ERROR(BUS_ERROR)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic        chk_en = 1'b0;
  logic        exp_busy = 1'b0, exp_mis = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic        exp_valid = 1'b0, exp_berr = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_ld = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // ---- specification-level model ----
  function automatic int unsigned size_f(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic mis_f(input logic [2:0] f3, input logic [1:0] off);
    int unsigned o = off;
    return (o % size_f(f3)) != 0;
  endfunction

  function automatic logic [3:0] be_f(input logic [2:0] f3, input logic [1:0] off);
    int unsigned o  = off;
    int unsigned sz = size_f(f3);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + sz);
    return be;
  endfunction

  function automatic logic [31:0] wdata_f(input logic [2:0] f3, input logic [31:0] d);
    int unsigned sz = size_f(f3);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] load_f(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rdata);
    int unsigned o  = off;
    int unsigned sz = size_f(f3);
    longint unsigned v, mask;
    v    = {32'b0, rdata} >> (8 * o);
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v    = v & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---- per-cycle compare ----
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("BUSY", 32'(BUSY), 32'(exp_busy));
      chk("MISALIGNED", 32'(MISALIGNED), 32'(exp_mis));
      chk("DMEM_REQ", 32'(DMEM_REQ), 32'(exp_req));
      chk("LOAD_VALID", 32'(LOAD_VALID), 32'(exp_valid));
      chk("BUS_ERROR", 32'(BUS_ERROR), 32'(exp_berr));
      chk("LOAD_DATA", LOAD_DATA, exp_ld);
      if (exp_req) begin
        chk("DMEM_WE", 32'(DMEM_WE), 32'(exp_we));
        chk("DMEM_ADDR", DMEM_ADDR, exp_addr);
        chk("DMEM_BE", 32'(DMEM_BE), 32'(exp_be));
        chk("DMEM_WDATA", DMEM_WDATA, exp_wdata);
      end
    end
  end

  // One instruction in MEM; ack_at = WAIT cycle (1-based) carrying the ack, 0 = never.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] regd,
                        input logic [31:0] wbd, input logic sel,
                        input int unsigned ack_at, input logic [31:0] rdata);
    logic mis, acked;
    logic [31:0] d;
    int unsigned n;
    mis = mis_f(f3, addr[1:0]);
    @(posedge CLK); #1;
    MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ALU_RESULT = addr;
    MEM_REG_DATA = regd; WB_FWD_DATA = wbd; MEM_FWD_SEL = sel; DMEM_ACK = 1'b0;
    exp_mis = (rd | wr) & mis; exp_busy = (rd | wr) & !mis;
    exp_req = 1'b0; exp_valid = 1'b0; exp_berr = 1'b0;
    if (!(rd | wr) || mis) begin
      @(posedge CLK); #1;
      MEM_READ = 1'b0; MEM_WRITE = 1'b0; exp_mis = 1'b0; exp_busy = 1'b0;
      return;
    end
    d         = sel ? wbd : regd;
    exp_we    = wr;
    exp_addr  = {addr[31:2], 2'b00};
    exp_be    = be_f(f3, addr[1:0]);
    exp_wdata = wr ? wdata_f(f3, d) : 32'h0;
    acked = 1'b0;
    n = 0;
    while (!acked && n < MAX_WAIT) begin
      @(posedge CLK); #1;
      n++;
      WB_FWD_DATA = ~wbd; MEM_FWD_SEL = ~sel;
      exp_req = 1'b1; exp_busy = 1'b1; exp_mis = 1'b0;
      if (n == 1) begin
        obs_addr = DMEM_ADDR; obs_be = DMEM_BE; obs_wdata = DMEM_WDATA; obs_we = DMEM_WE;
      end
      if (n == ack_at) begin
        DMEM_ACK = 1'b1; DMEM_RDATA = rdata; acked = 1'b1;
      end else begin
        DMEM_ACK = 1'b0; DMEM_RDATA = $urandom;
      end
    end
    // DONE: instruction still presented, stray ack must be ignored.
    @(posedge CLK); #1;
    DMEM_ACK = 1'b1; DMEM_RDATA = $urandom;
    exp_req = 1'b0; exp_busy = 1'b0;
    exp_valid = acked && !wr;
    if (acked && !wr) exp_ld = load_f(f3, addr[1:0], rdata);
    exp_berr = !acked;
    @(posedge CLK); #1;
    DMEM_ACK = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    exp_valid = 1'b0; exp_berr = 1'b0; exp_busy = 1'b0; exp_mis = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0; FUNCT3 = 3'b000;
    ALU_RESULT = '0; MEM_REG_DATA = '0; WB_FWD_DATA = '0; MEM_FWD_SEL = 1'b0;
    DMEM_RDATA = '0; DMEM_ACK = 1'b0;
    #12;
    chk("rst_REQ", 32'(DMEM_REQ), 32'h0);
    chk("rst_WE", 32'(DMEM_WE), 32'h0);
    chk("rst_ADDR", DMEM_ADDR, 32'h0);
    chk("rst_WDATA", DMEM_WDATA, 32'h0);
    chk("rst_BE", 32'(DMEM_BE), 32'h0);
    chk("rst_LOAD_DATA", LOAD_DATA, 32'h0);
    chk("rst_LOAD_VALID", 32'(LOAD_VALID), 32'h0);
    chk("rst_BUS_ERROR", 32'(BUS_ERROR), 32'h0);
    chk("rst_BUSY", 32'(BUSY), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    chk_en = 1'b1;

    // SW, ack in the second WAIT cycle
    access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'h0);
    chk("sw_addr", obs_addr, 32'h104);
    chk("sw_be", 32'(obs_be), 32'hF);
    chk("sw_wdata", obs_wdata, 32'hDEADBEEF);
    chk("sw_we", 32'(obs_we), 32'h1);
    // SB with load-then-store forwarding
    access(1'b0, 1'b1, 3'b000, 32'h203, 32'h0, 32'h11223344, 1'b1, 1, 32'h0);
    chk("sb_fwd_wdata", obs_wdata, 32'h44444444);
    chk("sb_fwd_be", 32'(obs_be), 32'h8);
    // Loads
    access(1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 32'h0, 1'b0, 1, 32'h00008000);
    chk("lb_lit", LOAD_DATA, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'b100, 32'h2001, 32'h0, 32'h0, 1'b0, 1, 32'h00008000);
    chk("lbu_lit", LOAD_DATA, 32'h00000080);
    access(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 32'h0, 1'b0, 1, 32'hBEEF0000);
    chk("lhu_lit", LOAD_DATA, 32'h0000BEEF);
    access(1'b1, 1'b0, 3'b001, 32'h0010, 32'h0, 32'h0, 1'b0, 3, 32'h00008001);
    chk("lh_lit", LOAD_DATA, 32'hFFFF8001);
    access(1'b1, 1'b0, 3'b010, 32'h0040, 32'h0, 32'h0, 1'b0, 2, 32'h12345678);
    chk("lw_lit", LOAD_DATA, 32'h12345678);
    // SH upper half; read+write together behaves as a write
    access(1'b0, 1'b1, 3'b001, 32'h0002, 32'hABCD1234, 32'h0, 1'b0, 1, 32'h0);
    chk("sh_wdata", obs_wdata, 32'h12341234);
    chk("sh_be", 32'(obs_be), 32'hC);
    access(1'b1, 1'b1, 3'b010, 32'h0048, 32'hCAFEF00D, 32'h0, 1'b0, 1, 32'hFFFFFFFF);
    chk("rw_we", 32'(obs_we), 32'h1);
    chk("rw_ld_kept", LOAD_DATA, 32'h12345678);
    // Misaligned accesses: no request, no stall
    access(1'b1, 1'b0, 3'b010, 32'h3002, 32'h0, 32'h0, 1'b0, 1, 32'h0);
    access(1'b0, 1'b1, 3'b001, 32'h0001, 32'h0, 32'h0, 1'b0, 1, 32'h0);
    access(1'b1, 1'b0, 3'b101, 32'h0003, 32'h0, 32'h0, 1'b0, 1, 32'h0);
    // Timeout, then ack exactly on the last allowed WAIT cycle
    access(1'b1, 1'b0, 3'b010, 32'h0080, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    chk("timeout_ld_kept", LOAD_DATA, 32'h12345678);
    access(1'b1, 1'b0, 3'b000, 32'h0083, 32'h0, 32'h0, 1'b0, MAX_WAIT, 32'h7F000000);
    chk("late_ack_lit", LOAD_DATA, 32'h0000007F);

    // Reset in the middle of WAIT
    @(posedge CLK); #1;
    MEM_READ = 1'b1; FUNCT3 = 3'b010; ALU_RESULT = 32'h500;
    exp_busy = 1'b1;
    @(posedge CLK); #1;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h500; exp_be = 4'hF; exp_wdata = 32'h0;
    @(posedge CLK); #1;
    #2;
    chk_en = 1'b0;
    RESET = 1'b0; MEM_READ = 1'b0;
    #1;
    chk("rst_mid_REQ", 32'(DMEM_REQ), 32'h0);
    chk("rst_mid_BUSY", 32'(BUSY), 32'h0);
    chk("rst_mid_LOAD_VALID", 32'(LOAD_VALID), 32'h0);
    chk("rst_mid_LOAD_DATA", LOAD_DATA, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hFFFFFFFF;
    @(posedge CLK); #1;
    DMEM_ACK = 1'b0;
    chk("post_rst_REQ", 32'(DMEM_REQ), 32'h0);
    chk("post_rst_LOAD_VALID", 32'(LOAD_VALID), 32'h0);
    exp_busy = 1'b0; exp_mis = 1'b0; exp_req = 1'b0; exp_valid = 1'b0;
    exp_berr = 1'b0; exp_ld = 32'h0;
    chk_en = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
